// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-source writeback arbiter plus load scoreboard; define REGFILE_WB_ARBITER_FWD_EN to add write forwarding ports.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         core_valid_i,
    output logic                         core_ready_o,
    input  logic [REG_ADDR_W-1:0]        core_rd_i,
    input  logic [XLEN-1:0]              core_data_i,
    input  logic                         mem_valid_i,
    output logic                         mem_ready_o,
    input  logic [REG_ADDR_W-1:0]        mem_rd_i,
    input  logic [XLEN-1:0]              mem_data_i,
    input  logic                         ld_issue_i,
    input  logic [REG_ADDR_W-1:0]        ld_rd_i,
`ifdef REGFILE_WB_ARBITER_FWD_EN
    input  logic [REG_ADDR_W-1:0]        sel_out_a_i,
    input  logic [REG_ADDR_W-1:0]        sel_out_b_i,
    output logic                         fwd_hit_a_o,
    output logic                         fwd_hit_b_o,
    output logic [XLEN-1:0]              fwd_data_a_o,
    output logic [XLEN-1:0]              fwd_data_b_o,
`endif
    output logic                         wb_we_o,
    output logic [REG_ADDR_W-1:0]        wb_rd_o,
    output logic [XLEN-1:0]              wb_data_o,
    output logic [(1<<REG_ADDR_W)-1:0]   rd_busy_o
);
    localparam int NREG = 1 << REG_ADDR_W;

    logic                  core_hold_q, core_hold_d;
    logic [REG_ADDR_W-1:0] core_rd_q, core_rd_d;
    logic [XLEN-1:0]       core_data_q, core_data_d;
    logic                  mem_hold_q, mem_hold_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic [XLEN-1:0]       mem_data_q, mem_data_d;
    logic                  prefer_mem_q, prefer_mem_d;
    logic                  wb_we_q, wb_we_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  core_gnt, mem_gnt, core_acc, mem_acc;

    // Round-robin grant over held entries; pointer breaks ties only when both are held
    always_comb begin
        mem_gnt      = mem_hold_q && (!core_hold_q || prefer_mem_q);
        core_gnt     = core_hold_q && !mem_gnt;
        prefer_mem_d = mem_gnt ? 1'b0 : (core_gnt ? 1'b1 : prefer_mem_q);
    end

    // Ready comes only from hold state and grant, never from valid
    always_comb begin
        core_ready_o = reset_i && (!core_hold_q || core_gnt);
        mem_ready_o  = reset_i && (!mem_hold_q || mem_gnt);
        core_acc     = core_valid_i && core_ready_o;
        mem_acc      = mem_valid_i && mem_ready_o;
    end

    // Holding registers refill on accept and drain on grant
    always_comb begin
        core_hold_d = core_acc || (core_hold_q && !core_gnt);
        core_rd_d   = core_acc ? core_rd_i : core_rd_q;
        core_data_d = core_acc ? core_data_i : core_data_q;
        mem_hold_d  = mem_acc || (mem_hold_q && !mem_gnt);
        mem_rd_d    = mem_acc ? mem_rd_i : mem_rd_q;
        mem_data_d  = mem_acc ? mem_data_i : mem_data_q;
    end

    // Write stage: x0 entries are consumed but never enable the bank write
    always_comb begin
        wb_we_d   = core_gnt ? (core_rd_q != '0) : (mem_gnt ? (mem_rd_q != '0) : 1'b0);
        wb_rd_d   = core_gnt ? core_rd_q : (mem_gnt ? mem_rd_q : wb_rd_q);
        wb_data_d = core_gnt ? core_data_q : (mem_gnt ? mem_data_q : wb_data_q);
    end

    // Scoreboard: clear on mem grant, then set on load issue so back-to-back loads stay busy
    always_comb begin
        busy_d = busy_q;
        if (mem_gnt) busy_d[mem_rd_q] = 1'b0;
        if (ld_issue_i && ld_rd_i != '0) busy_d[ld_rd_i] = 1'b1;
    end

    // State registers; reset drops held requests and the scoreboard without writing
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            core_hold_q  <= 1'b0;
            core_rd_q    <= '0;
            core_data_q  <= '0;
            mem_hold_q   <= 1'b0;
            mem_rd_q     <= '0;
            mem_data_q   <= '0;
            prefer_mem_q <= 1'b1;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            core_hold_q  <= core_hold_d;
            core_rd_q    <= core_rd_d;
            core_data_q  <= core_data_d;
            mem_hold_q   <= mem_hold_d;
            mem_rd_q     <= mem_rd_d;
            mem_data_q   <= mem_data_d;
            prefer_mem_q <= prefer_mem_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            busy_q       <= busy_d;
        end
    end

    assign wb_we_o   = wb_we_q;
    assign wb_rd_o   = wb_rd_q;
    assign wb_data_o = wb_data_q;
    assign rd_busy_o = busy_q;

`ifdef REGFILE_WB_ARBITER_FWD_EN
    // Expose the value being written this cycle to the two read ports
    always_comb begin
        fwd_hit_a_o  = wb_we_q && wb_rd_q == sel_out_a_i && wb_rd_q != '0;
        fwd_hit_b_o  = wb_we_q && wb_rd_q == sel_out_b_i && wb_rd_q != '0;
        fwd_data_a_o = wb_data_q;
        fwd_data_b_o = wb_data_q;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed table-driven bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cv, cr, mv, mr, li, we;
    logic [4:0]  crd, mrd, lrd, wrd;
    logic [31:0] cd, md, wdata, busy;
`ifdef REGFILE_WB_ARBITER_FWD_EN
    logic [4:0]  sel_a, sel_b;
    logic        hit_a, hit_b;
    logic [31:0] fdata_a, fdata_b;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clock_i(clk), .reset_i(rst_n),
        .core_valid_i(cv), .core_ready_o(cr), .core_rd_i(crd), .core_data_i(cd),
        .mem_valid_i(mv), .mem_ready_o(mr), .mem_rd_i(mrd), .mem_data_i(md),
        .ld_issue_i(li), .ld_rd_i(lrd),
`ifdef REGFILE_WB_ARBITER_FWD_EN
        .sel_out_a_i(sel_a), .sel_out_b_i(sel_b),
        .fwd_hit_a_o(hit_a), .fwd_hit_b_o(hit_b),
        .fwd_data_a_o(fdata_a), .fwd_data_b_o(fdata_b),
`endif
        .wb_we_o(we), .wb_rd_o(wrd), .wb_data_o(wdata), .rd_busy_o(busy)
    );

    typedef struct {
        logic cv; logic [4:0] crd; logic [31:0] cd;
        logic mv; logic [4:0] mrd; logic [31:0] md;
        logic li; logic [4:0] lrd;
        logic we; logic [4:0] rd; logic [31:0] data; logic [31:0] busy;
        logic cr; logic mr;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(logic a_cv, logic [4:0] a_crd, logic [31:0] a_cd,
                                logic a_mv, logic [4:0] a_mrd, logic [31:0] a_md,
                                logic a_li, logic [4:0] a_lrd,
                                logic e_we, logic [4:0] e_rd, logic [31:0] e_data,
                                logic [31:0] e_busy, logic e_cr, logic e_mr);
        vec_t v;
        v.cv = a_cv; v.crd = a_crd; v.cd = a_cd;
        v.mv = a_mv; v.mrd = a_mrd; v.md = a_md;
        v.li = a_li; v.lrd = a_lrd;
        v.we = e_we; v.rd = e_rd; v.data = e_data; v.busy = e_busy;
        v.cr = e_cr; v.mr = e_mr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        cv = 0; crd = 0; cd = 0; mv = 0; mrd = 0; md = 0; li = 0; lrd = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        cyc();
        chk("rst.wb_we", 32'(we), 0);
        chk("rst.wb_rd", 32'(wrd), 0);
        chk("rst.wb_data", wdata, 0);
        chk("rst.rd_busy", busy, 0);
        chk("rst.core_ready", 32'(cr), 0);
        chk("rst.mem_ready", 32'(mr), 0);
        rst_n = 1;
        #1;
        chk("rst.core_ready_after", 32'(cr), 1);
        chk("rst.mem_ready_after", 32'(mr), 1);
    endtask

    initial begin
        vecs[0]  = mk(1,5,'h1234, 0,0,0,    0,0, 0,0,'h0,    0,    1,1);
        vecs[1]  = mk(0,0,0,      0,0,0,    0,0, 1,5,'h1234, 0,    1,1);
        vecs[2]  = mk(0,0,0,      0,0,0,    0,0, 0,5,'h1234, 0,    1,1);
        vecs[3]  = mk(1,1,'hA,    1,2,'hB,  0,0, 0,5,'h1234, 0,    0,1);
        vecs[4]  = mk(1,1,'hA,    1,2,'hB,  0,0, 1,2,'hB,    0,    1,0);
        vecs[5]  = mk(1,1,'hA,    1,2,'hB,  0,0, 1,1,'hA,    0,    0,1);
        vecs[6]  = mk(1,1,'hA,    1,2,'hB,  0,0, 1,2,'hB,    0,    1,0);
        vecs[7]  = mk(1,1,'hA,    1,2,'hB,  0,0, 1,1,'hA,    0,    0,1);
        vecs[8]  = mk(1,1,'hA,    1,2,'hB,  0,0, 1,2,'hB,    0,    1,0);
        vecs[9]  = mk(0,0,0,      0,0,0,    0,0, 1,1,'hA,    0,    1,1);
        vecs[10] = mk(0,0,0,      0,0,0,    0,0, 1,2,'hB,    0,    1,1);
        vecs[11] = mk(0,0,0,      0,0,0,    0,0, 0,2,'hB,    0,    1,1);
        vecs[12] = mk(0,0,0,      0,0,0,    1,7, 0,2,'hB,    'h80, 1,1);
        vecs[13] = mk(0,0,0,      1,7,'h77, 0,0, 0,2,'hB,    'h80, 1,1);
        vecs[14] = mk(0,0,0,      0,0,0,    1,7, 1,7,'h77,   'h80, 1,1);
        vecs[15] = mk(0,0,0,      1,7,'h78, 0,0, 0,7,'h77,   'h80, 1,1);
        vecs[16] = mk(0,0,0,      0,0,0,    0,0, 1,7,'h78,   0,    1,1);
        vecs[17] = mk(1,0,'hFFFF, 0,0,0,    1,0, 0,7,'h78,   0,    1,1);
        vecs[18] = mk(0,0,0,      0,0,0,    0,0, 0,0,'hFFFF, 0,    1,1);
        vecs[19] = mk(0,0,0,      0,0,0,    1,3, 0,0,'hFFFF, 'h08, 1,1);
        vecs[20] = mk(0,0,0,      0,0,0,    1,3, 0,0,'hFFFF, 'h08, 1,1);
        vecs[21] = mk(1,3,'h33,   0,0,0,    0,0, 0,0,'hFFFF, 'h08, 1,1);
        vecs[22] = mk(0,0,0,      0,0,0,    0,0, 1,3,'h33,   'h08, 1,1);
        vecs[23] = mk(1,4,'h41,   1,4,'h42, 0,0, 0,3,'h33,   'h08, 0,1);
        vecs[24] = mk(0,0,0,      0,0,0,    0,0, 1,4,'h42,   'h08, 1,1);
        vecs[25] = mk(0,0,0,      0,0,0,    0,0, 1,4,'h41,   'h08, 1,1);
        vecs[26] = mk(0,0,0,      0,0,0,    0,0, 0,4,'h41,   'h08, 1,1);

`ifdef REGFILE_WB_ARBITER_FWD_EN
        sel_a = 0;
        sel_b = 0;
`endif
        idle();
        rst_n = 0;
        cyc();
        do_reset();

        for (int i = 0; i < 27; i++) begin
            cv = vecs[i].cv; crd = vecs[i].crd; cd = vecs[i].cd;
            mv = vecs[i].mv; mrd = vecs[i].mrd; md = vecs[i].md;
            li = vecs[i].li; lrd = vecs[i].lrd;
            cyc();
            chk($sformatf("v%0d.wb_we", i), 32'(we), 32'(vecs[i].we));
            chk($sformatf("v%0d.wb_rd", i), 32'(wrd), 32'(vecs[i].rd));
            chk($sformatf("v%0d.wb_data", i), wdata, vecs[i].data);
            chk($sformatf("v%0d.rd_busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d.core_ready", i), 32'(cr), 32'(vecs[i].cr));
            chk($sformatf("v%0d.mem_ready", i), 32'(mr), 32'(vecs[i].mr));
        end
        idle();

`ifdef REGFILE_WB_ARBITER_FWD_EN
        cv = 1; crd = 3; cd = 'h55;
        sel_a = 3; sel_b = 0;
        cyc();
        idle();
        chk("fwd.pre_hit_a", 32'(hit_a), 0);
        cyc();
        chk("fwd.wb_we", 32'(we), 1);
        chk("fwd.hit_a", 32'(hit_a), 1);
        chk("fwd.data_a", fdata_a, 'h55);
        chk("fwd.hit_b", 32'(hit_b), 0);
        sel_b = 3; sel_a = 2;
        #1;
        chk("fwd.hit_b_sel3", 32'(hit_b), 1);
        chk("fwd.data_b", fdata_b, 'h55);
        chk("fwd.hit_a_sel2", 32'(hit_a), 0);
        cyc();
        chk("fwd.hit_b_idle", 32'(hit_b), 0);
`endif

        do_reset();
        cv = 1; crd = 9; cd = 'h99; mv = 1; mrd = 10; md = 'hAA; li = 1; lrd = 7;
        cyc();
        idle();
        chk("mid.rd_busy_set", busy, 'h80);
        chk("mid.core_ready_full", 32'(cr), 0);
        rst_n = 0;
        cyc();
        chk("mid.wb_we", 32'(we), 0);
        chk("mid.rd_busy", busy, 0);
        chk("mid.wb_rd", 32'(wrd), 0);
        chk("mid.wb_data", wdata, 0);
        rst_n = 1;
        #1;
        chk("mid.core_ready", 32'(cr), 1);
        chk("mid.mem_ready", 32'(mr), 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("mid.no_wb%0d", i), 32'(we), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-bank write port between two writeback sources: the core path (ALU/PC results) and the load-return path from memory.
- Each source uses a valid/ready handshake into a one-entry holding register.
- A round-robin arbiter drives one registered write per cycle.
- A 32-entry scoreboard tracks destination registers of outstanding loads so the issue logic can stall on RAW hazards.

Parameters:
- XLEN, 32, data width of the written value.
- REG_ADDR_W, 5, register index width (2**REG_ADDR_W registers; index 0 is hard-wired zero).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; one clock, reset asserted when low at a rising edge.
- core_valid  in  1  core writeback request.
- core_ready  out  1  core request accepted when core_valid&&core_ready.
- core_rd  in  REG_ADDR_W  core destination register.
- core_data  in  XLEN  core writeback value.
- mem_valid  in  1  load-return request.
- mem_ready  out  1  load return accepted when mem_valid&&mem_ready.
- mem_rd  in  REG_ADDR_W  load destination register.
- mem_data  in  XLEN  load value.
- ld_issue  in  1  a load was issued this cycle; marks ld_rd busy.
- ld_rd  in  REG_ADDR_W  destination of the issued load.
- wb_we  out  1  register-bank write enable.
- wb_rd  out  REG_ADDR_W  register-bank write index (sel_in).
- wb_data  out  XLEN  register-bank write data.
- rd_busy  out  2**REG_ADDR_W  scoreboard; bit i=1 means a load to register i is outstanding.

Behaviour:
- Reset (reset==0 at edge):
  - Both holding registers are empty.
  - wb_we=0, wb_rd=0, wb_data=0, rd_busy=0.
  - The round-robin pointer is set to favour mem.
  - core_ready and mem_ready are low during the reset cycle, then 1 with empty holds.
  - Reset mid-operation discards held requests and the scoreboard without writing.
- Holding registers: one per source.
  - x_ready = hold_x empty OR hold_x granted this cycle (no bubble under continuous traffic).
  - Accepted rd/data are captured at the edge.
- Arbitration: combinational over the held entries.
  - If only one is held, it is granted.
  - If both are held, the source not granted last time is granted.
  - The pointer updates only on a grant.
  - A source that is not granted keeps its entry and drops ready until it drains; worst-case wait is 1 cycle.
- Write stage: wb_we, wb_rd and wb_data are registered from the granted entry. Latency is 1 cycle from accept to hold, and 1 more from hold to wb_we (2 cycles valid-to-write).
- x0 handling:
  - A granted entry with rd==0 is consumed, but wb_we=0 (wb_rd/wb_data still update).
  - ld_issue with ld_rd==0 never sets a busy bit.
- Scoreboard:
  - Set bit ld_rd on ld_issue.
  - Clear bit mem_rd when the mem entry is granted (not on accept).
  - Same-cycle set and clear of the same index: set wins (back-to-back loads to one rd).
  - ld_issue to an already-busy register leaves it busy.
  - Core grants never touch rd_busy.
- Same-cycle writes: core and mem held entries with equal rd are written in grant order; the later write wins in the bank.
- There is no internal combinational path from valid to ready; ready depends only on hold state and grant.

Optional Feature:
- Macro: REGFILE_WB_ARBITER_FWD_EN.
- Defined:
  - Adds inputs sel_out_a and sel_out_b (REG_ADDR_W each).
  - Adds outputs fwd_hit_a and fwd_hit_b (1 each) and fwd_data_a and fwd_data_b (XLEN each).
  - fwd_hit_x=1 when wb_we && wb_rd==sel_out_x && wb_rd!=0; fwd_data_x=wb_data, combinational.
  - This lets readers see the value being written this cycle.
- Undefined: these ports do not exist and no comparators are built; port list and behaviour are otherwise identical.

Test Plan:
- Reset then core_valid=1, rd=5, data=0x1234 for one cycle -> wb_we=1, wb_rd=5, wb_data=0x1234 exactly 2 cycles later; core_ready stays 1.
- Both valid every cycle (core rd=1/data=0xA, mem rd=2/data=0xB), held 6 cycles -> wb_rd alternates 2,1,2,1 (mem first after reset); no cycle without wb_we once started.
- ld_issue rd=7 -> rd_busy[7]=1 next cycle; mem return rd=7 -> bit clears the cycle after grant; ld_issue rd=7 in the same cycle as that grant -> bit stays 1.
- Core write rd=0 data=0xFFFF -> wb_we remains 0; ld_issue rd=0 -> rd_busy unchanged (0).
- Reset asserted while both holds are full and rd_busy=0x80 -> next cycle wb_we=0, rd_busy=0, both ready=1; held writes never appear.
- FWD_EN: write rd=3, data=0x55 with sel_out_a=3, sel_out_b=0 -> in the wb_we cycle fwd_hit_a=1, fwd_data_a=0x55, fwd_hit_b=0.
